boot_init_sequencer: RTL and testbench
======================================

// Module: boot_init_sequencer
// PURPOSE
//  Synthesizable boot controller sitting between the system and Unit_Execution.
//  After reset it zero-fills the scoreboard RAM(s) and streams a program into instruction memory.
//  It then pulses the execution-unit reset and raises its enable.
//  Replaces bench-only memory preloading; generalised in RAM depth/width and number of cleared RAMs.
// PARAMETERS
//  SB_DEPTH     128  entries per cleared RAM (scoreboard)
//  SB_AW        7    clear address width, 2**SB_AW >= SB_DEPTH
//  NUM_CLR_CH   1    number of RAMs cleared in parallel (shared address, one WE each)
//  IM_DEPTH     512  instruction memory words
//  IM_AW        9    instruction address width, 2**IM_AW >= IM_DEPTH
//  IM_DW        64   instruction word width
//  EXEC_RST_CYC 2    cycles oExecReset is held high before enable
// PORTS
//  Clock          in   1            system clock, rising edge
//  Reset          in   1            synchronous, active-high
//  iReboot        in   1            restart full boot sequence
//  iCodeValid     in   1            program word valid
//  iCodeData      in   IM_DW        program word
//  iCodeLast      in   1            qualifies final program word
//  oCodeReady     out  1            sequencer accepts program word
//  oImWe          out  1            instruction memory write enable
//  oImAddr        out  IM_AW        instruction memory address
//  oImData        out  IM_DW        instruction memory write data
//  oClrWe         out  NUM_CLR_CH   clear write enables (data is implicitly 0)
//  oClrAddr       out  SB_AW        clear address
//  oExecReset     out  1            reset to execution unit
//  oEnable        out  1            enable to execution unit
//  oBusy          out  1            high in CLEAR/LOAD/HOLD
//  oError         out  1            sticky boot failure
//  oCodeWords     out  IM_AW+1      words loaded in last boot
// BEHAVIOUR
//  States: RESET, CLEAR, LOAD, HOLD, RUN, ERR; outputs decoded from registered state/counters.
//  Reset high: state=RESET, counters=0, every output 0 (oCodeWords=0).
//  RESET -> CLEAR unconditionally on the first edge with Reset low.
//  CLEAR: oClrWe all-ones, oClrAddr 0..SB_DEPTH-1, one per cycle; exactly SB_DEPTH cycles -> LOAD.
//  LOAD: oCodeReady=1; transfer when iCodeValid&oCodeReady. oImWe=transfer (comb),
//   oImAddr=ptr, oImData=iCodeData; ptr++ and oCodeWords++ per transfer; valid gaps allowed.
//  Transfer with iCodeLast -> HOLD. Zero-length program impossible; min 1 word.
//  Overflow: transfer at ptr=IM_DEPTH-1 without iCodeLast -> ERR (word itself is written).
//   Transfer at IM_DEPTH-1 with iCodeLast is legal -> HOLD.
//  HOLD: oExecReset=1 for exactly EXEC_RST_CYC cycles -> RUN.
//  RUN: oEnable=1, held until Reset or iReboot.
//  ERR: oError=1, oEnable=0, oCodeReady=0; exits only on Reset or iReboot.
//  iReboot (any state but RESET): next state CLEAR, counters cleared, oError cleared;
//   oCodeReady forced 0 in the iReboot cycle, so a coincident word is not accepted.
//  Reset beats iReboot. Reset mid-CLEAR/LOAD: outputs 0 next cycle, full sequence restarts.
//  oCodeWords holds its value through HOLD/RUN/ERR; cleared on entry to CLEAR.
// CONFIGURATION
//  BOOT_CHECKSUM_EN defined: extra input iCodeChecksum [IM_DW-1:0]; XOR of all loaded words
//   (including last) compared on the last-word transfer; mismatch -> ERR instead of HOLD.
//  Undefined: port absent, no check, no accumulator register.
// STRUCTURE
//  Shared include boot_defs.vh: state encodings, state width, default depths/widths.
//  One sub-module boot_addr_counter (clear/enable/terminal-count up-counter, parametrised width),
//   instanced for clear address, program pointer and hold counter.
// TESTING
//  T1 defaults, Reset 2 cycles: oClrWe=1 exactly 128 cycles, addr 0..127, then oCodeReady=1.
//  T2 words 'hA0..'hA3 with 1-cycle valid gaps, last on 4th: IM writes addr 0..3,
//   oCodeWords=4, oExecReset high 2 cycles, then oEnable=1.
//  T3 IM_DEPTH=8, 8 words without last: oError=1 after 8th, oCodeReady=0, oEnable stays 0.
//  T4 IM_DEPTH=8, last on 8th word: no error, oEnable=1 after HOLD.
//  T5 iReboot in RUN with iCodeValid high: oEnable=0 next cycle, oClrAddr restarts at 0,
//   no IM write; Reset mid-CLEAR (addr 50): all outputs 0, clear restarts at 0.
//  T6 BOOT_CHECKSUM_EN, words 1,2,4 with checksum 7 -> RUN; checksum 6 -> oError=1.

Source files
------------

// File: rtl/boot_init_sequencer_pkg.sv
// Shared definitions for the boot sequencer: state encodings, state width
// and default memory geometry.
package boot_init_sequencer_pkg;

  localparam int BOOT_STATE_W = 3;

  typedef enum logic [BOOT_STATE_W-1:0] {
    ST_RESET = 3'd0,
    ST_CLEAR = 3'd1,
    ST_LOAD  = 3'd2,
    ST_HOLD  = 3'd3,
    ST_RUN   = 3'd4,
    ST_ERR   = 3'd5
  } boot_state_t;

  localparam int DEF_SB_DEPTH     = 128;
  localparam int DEF_SB_AW        = 7;
  localparam int DEF_NUM_CLR_CH   = 1;
  localparam int DEF_IM_DEPTH     = 512;
  localparam int DEF_IM_AW        = 9;
  localparam int DEF_IM_DW        = 64;
  localparam int DEF_EXEC_RST_CYC = 2;

endpackage

// File: rtl/boot_addr_counter.sv
// Up-counter with synchronous clear (priority over enable) and a
// terminal-count flag raised while the count equals LAST.
module boot_addr_counter #(
  parameter int           W    = 8,
  parameter logic [W-1:0] LAST = '1
) (
  input  logic         Clock,
  input  logic         clr,
  input  logic         en,
  output logic [W-1:0] cnt,
  output logic         tc
);

  always_ff @(posedge Clock) begin
    if (clr)
      cnt <= '0;
    else if (en)
      cnt <= cnt + W'(1);
  end

  assign tc = (cnt == LAST);

endmodule

// File: rtl/boot_init_sequencer.sv
// Boot controller: zero-fills scoreboard RAMs, streams the program into
// instruction memory, then resets and enables the execution unit.
// Optional program checksum check is built when BOOT_CHECKSUM_EN is defined.
//
// state | meaning
// RESET | held in reset, all outputs low
// CLEAR | writing zero to scoreboard address 0..SB_DEPTH-1
// LOAD  | accepting program words into instruction memory
// HOLD  | execution-unit reset asserted for EXEC_RST_CYC cycles
// RUN   | execution unit enabled
// ERR   | boot failed (overflow or checksum), waits for Reset/iReboot
module boot_init_sequencer
  import boot_init_sequencer_pkg::*;
#(
  parameter int SB_DEPTH     = DEF_SB_DEPTH,
  parameter int SB_AW        = DEF_SB_AW,
  parameter int NUM_CLR_CH   = DEF_NUM_CLR_CH,
  parameter int IM_DEPTH     = DEF_IM_DEPTH,
  parameter int IM_AW        = DEF_IM_AW,
  parameter int IM_DW        = DEF_IM_DW,
  parameter int EXEC_RST_CYC = DEF_EXEC_RST_CYC
) (
  input  logic                  Clock,
  input  logic                  Reset,
  input  logic                  iReboot,
  input  logic                  iCodeValid,
  input  logic [IM_DW-1:0]      iCodeData,
  input  logic                  iCodeLast,
`ifdef BOOT_CHECKSUM_EN
  input  logic [IM_DW-1:0]      iCodeChecksum,
`endif
  output logic                  oCodeReady,
  output logic                  oImWe,
  output logic [IM_AW-1:0]      oImAddr,
  output logic [IM_DW-1:0]      oImData,
  output logic [NUM_CLR_CH-1:0] oClrWe,
  output logic [SB_AW-1:0]      oClrAddr,
  output logic                  oExecReset,
  output logic                  oEnable,
  output logic                  oBusy,
  output logic                  oError,
  output logic [IM_AW:0]        oCodeWords
);

  localparam int PTR_W  = IM_AW + 1;
  localparam int HOLD_W = $clog2(EXEC_RST_CYC + 1);

  boot_state_t state;

  logic              reboot_req;
  logic              xfer;
  logic              last_ok;
  logic              clr_clr, ptr_clr, hold_clr;
  logic              clr_tc, ptr_tc, hold_tc;
  logic [SB_AW-1:0]  clr_cnt;
  logic [PTR_W-1:0]  ptr;
  logic [HOLD_W-1:0] hold_cnt;

  assign reboot_req = iReboot && (state != ST_RESET);
  assign oCodeReady = (state == ST_LOAD) && !iReboot && !Reset;
  assign xfer       = oCodeReady && iCodeValid;

  // Every counter restarts whenever the sequence (re)enters CLEAR.
  assign clr_clr  = Reset || reboot_req || (state != ST_CLEAR);
  assign ptr_clr  = Reset || reboot_req || (state == ST_RESET);
  assign hold_clr = Reset || reboot_req || (state != ST_HOLD);

  boot_addr_counter #(.W(SB_AW), .LAST(SB_AW'(SB_DEPTH - 1))) u_clr_cnt (
    .Clock (Clock),
    .clr   (clr_clr),
    .en    (state == ST_CLEAR),
    .cnt   (clr_cnt),
    .tc    (clr_tc)
  );

  // Pointer is one bit wider so it doubles as the loaded-word count.
  boot_addr_counter #(.W(PTR_W), .LAST(PTR_W'(IM_DEPTH - 1))) u_ptr_cnt (
    .Clock (Clock),
    .clr   (ptr_clr),
    .en    (xfer),
    .cnt   (ptr),
    .tc    (ptr_tc)
  );

  boot_addr_counter #(.W(HOLD_W), .LAST(HOLD_W'(EXEC_RST_CYC - 1))) u_hold_cnt (
    .Clock (Clock),
    .clr   (hold_clr),
    .en    (state == ST_HOLD),
    .cnt   (hold_cnt),
    .tc    (hold_tc)
  );

`ifdef BOOT_CHECKSUM_EN
  logic [IM_DW-1:0] csum;

  always_ff @(posedge Clock) begin
    if (ptr_clr)
      csum <= '0;
    else if (xfer)
      csum <= csum ^ iCodeData;
  end

  assign last_ok = ((csum ^ iCodeData) == iCodeChecksum);
`else
  assign last_ok = 1'b1;
`endif

  always_ff @(posedge Clock) begin
    if (Reset) begin
      state <= ST_RESET;
    end else if (reboot_req) begin
      state <= ST_CLEAR;
    end else begin
      case (state)
        ST_RESET: state <= ST_CLEAR;
        ST_CLEAR: if (clr_tc) state <= ST_LOAD;
        ST_LOAD: begin
          if (xfer) begin
            if (iCodeLast)
              state <= last_ok ? ST_HOLD : ST_ERR;
            else if (ptr_tc)
              state <= ST_ERR;
          end
        end
        ST_HOLD:  if (hold_tc) state <= ST_RUN;
        ST_RUN:   state <= ST_RUN;
        ST_ERR:   state <= ST_ERR;
        default:  state <= ST_RESET;
      endcase
    end
  end

  assign oImWe      = xfer;
  assign oImAddr    = ptr[IM_AW-1:0];
  assign oImData    = (state == ST_LOAD) ? iCodeData : '0;
  assign oClrWe     = {NUM_CLR_CH{state == ST_CLEAR}};
  assign oClrAddr   = (state == ST_CLEAR) ? clr_cnt : '0;
  assign oExecReset = (state == ST_HOLD);
  assign oEnable    = (state == ST_RUN);
  assign oBusy      = (state == ST_CLEAR) || (state == ST_LOAD) || (state == ST_HOLD);
  assign oError     = (state == ST_ERR);
  assign oCodeWords = ptr;

endmodule

// File: tb/tb_boot_init_sequencer.sv
// Directed bench for boot_init_sequencer: a default-geometry instance and a
// small instance (IM_DEPTH=8) for overflow, last-at-end and checksum cases.
module tb_boot_init_sequencer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int nvec = 0;
  int nerr = 0;

  // instance A: default parameters
  logic        a_rst, a_reboot, a_valid, a_last;
  logic [63:0] a_data;
  logic        a_ready, a_imwe, a_xrst, a_en, a_busy, a_err;
  logic [8:0]  a_imaddr;
  logic [63:0] a_imdata;
  logic [0:0]  a_clrwe;
  logic [6:0]  a_clraddr;
  logic [9:0]  a_words;

  // instance B: SB_DEPTH=4, IM_DEPTH=8, two clear channels, 3 hold cycles
  logic        b_rst, b_reboot, b_valid, b_last;
  logic [63:0] b_data;
  logic        b_ready, b_imwe, b_xrst, b_en, b_busy, b_err;
  logic [2:0]  b_imaddr;
  logic [63:0] b_imdata;
  logic [1:0]  b_clrwe;
  logic [1:0]  b_clraddr;
  logic [3:0]  b_words;

`ifdef BOOT_CHECKSUM_EN
  logic [63:0] a_cks, b_cks;
`endif

  boot_init_sequencer dut_a (
    .Clock(clk), .Reset(a_rst), .iReboot(a_reboot), .iCodeValid(a_valid),
    .iCodeData(a_data), .iCodeLast(a_last),
`ifdef BOOT_CHECKSUM_EN
    .iCodeChecksum(a_cks),
`endif
    .oCodeReady(a_ready), .oImWe(a_imwe), .oImAddr(a_imaddr), .oImData(a_imdata),
    .oClrWe(a_clrwe), .oClrAddr(a_clraddr), .oExecReset(a_xrst), .oEnable(a_en),
    .oBusy(a_busy), .oError(a_err), .oCodeWords(a_words)
  );

  boot_init_sequencer #(
    .SB_DEPTH(4), .SB_AW(2), .NUM_CLR_CH(2), .IM_DEPTH(8), .IM_AW(3),
    .IM_DW(64), .EXEC_RST_CYC(3)
  ) dut_b (
    .Clock(clk), .Reset(b_rst), .iReboot(b_reboot), .iCodeValid(b_valid),
    .iCodeData(b_data), .iCodeLast(b_last),
`ifdef BOOT_CHECKSUM_EN
    .iCodeChecksum(b_cks),
`endif
    .oCodeReady(b_ready), .oImWe(b_imwe), .oImAddr(b_imaddr), .oImData(b_imdata),
    .oClrWe(b_clrwe), .oClrAddr(b_clraddr), .oExecReset(b_xrst), .oEnable(b_en),
    .oBusy(b_busy), .oError(b_err), .oCodeWords(b_words)
  );

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reboot B from wherever it is and walk it through its 4-cycle clear.
  task automatic b_reboot_to_load();
    b_reboot = 1'b1;
    step();
    b_reboot = 1'b0;
    chk("b_rb_clrwe", 128'(b_clrwe), 128'(2'b11));
    chk("b_rb_clraddr", 128'(b_clraddr), 128'(0));
    chk("b_rb_err", 128'(b_err), 128'(0));
    chk("b_rb_words", 128'(b_words), 128'(0));
    for (int i = 0; i < 4; i++) step();
    chk("b_rb_ready", 128'(b_ready), 128'(1));
  endtask

  logic [63:0] acc;

  initial begin
    a_rst = 1'b1; a_reboot = 1'b0; a_valid = 1'b0; a_last = 1'b0; a_data = '0;
    b_rst = 1'b1; b_reboot = 1'b0; b_valid = 1'b0; b_last = 1'b0; b_data = '0;
`ifdef BOOT_CHECKSUM_EN
    a_cks = '0; b_cks = '0;
`endif
    step();
    step();

    // reset state
    chk("a_rst_clrwe", 128'(a_clrwe), 128'(0));
    chk("a_rst_clraddr", 128'(a_clraddr), 128'(0));
    chk("a_rst_ready", 128'(a_ready), 128'(0));
    chk("a_rst_imwe", 128'(a_imwe), 128'(0));
    chk("a_rst_imaddr", 128'(a_imaddr), 128'(0));
    chk("a_rst_xrst", 128'(a_xrst), 128'(0));
    chk("a_rst_en", 128'(a_en), 128'(0));
    chk("a_rst_busy", 128'(a_busy), 128'(0));
    chk("a_rst_err", 128'(a_err), 128'(0));
    chk("a_rst_words", 128'(a_words), 128'(0));
    chk("b_rst_clrwe", 128'(b_clrwe), 128'(0));
    chk("b_rst_busy", 128'(b_busy), 128'(0));

    // T1: clear sweep of 128 entries
    a_rst = 1'b0;
    for (int i = 0; i < 128; i++) begin
      step();
      chk("t1_clrwe", 128'(a_clrwe), 128'(1));
      chk("t1_clraddr", 128'(a_clraddr), 128'(i));
      chk("t1_ready_low", 128'(a_ready), 128'(0));
    end
    step();
    chk("t1_clrwe_done", 128'(a_clrwe), 128'(0));
    chk("t1_ready", 128'(a_ready), 128'(1));
    chk("t1_busy", 128'(a_busy), 128'(1));

    // T2: four words with one-cycle valid gaps
`ifdef BOOT_CHECKSUM_EN
    a_cks = 64'hA0 ^ 64'hA1 ^ 64'hA2 ^ 64'hA3;
`endif
    for (int k = 0; k < 4; k++) begin
      a_valid = 1'b1;
      a_data  = 64'hA0 + 64'(k);
      a_last  = (k == 3);
      #1;
      chk("t2_imwe", 128'(a_imwe), 128'(1));
      chk("t2_imaddr", 128'(a_imaddr), 128'(k));
      chk("t2_imdata", 128'(a_imdata), 128'(64'hA0 + 64'(k)));
      step();
      a_valid = 1'b0;
      a_last  = 1'b0;
      if (k < 3) begin
        #1;
        chk("t2_gap_imwe", 128'(a_imwe), 128'(0));
        chk("t2_gap_words", 128'(a_words), 128'(k + 1));
        step();
      end
    end
    chk("t2_hold1_xrst", 128'(a_xrst), 128'(1));
    chk("t2_hold1_en", 128'(a_en), 128'(0));
    chk("t2_hold1_ready", 128'(a_ready), 128'(0));
    chk("t2_words", 128'(a_words), 128'(4));
    step();
    chk("t2_hold2_xrst", 128'(a_xrst), 128'(1));
    step();
    chk("t2_run_xrst", 128'(a_xrst), 128'(0));
    chk("t2_run_en", 128'(a_en), 128'(1));
    chk("t2_run_busy", 128'(a_busy), 128'(0));
    chk("t2_run_words", 128'(a_words), 128'(4));
    step();
    chk("t2_run_en_hold", 128'(a_en), 128'(1));

    // T5a: reboot in RUN with a word offered
    a_reboot = 1'b1;
    a_valid  = 1'b1;
    a_data   = 64'h55;
    #1;
    chk("t5_rb_ready", 128'(a_ready), 128'(0));
    chk("t5_rb_imwe", 128'(a_imwe), 128'(0));
    step();
    a_reboot = 1'b0;
    #1;
    chk("t5_en_off", 128'(a_en), 128'(0));
    chk("t5_clrwe", 128'(a_clrwe), 128'(1));
    chk("t5_clraddr0", 128'(a_clraddr), 128'(0));
    chk("t5_imwe", 128'(a_imwe), 128'(0));
    chk("t5_words_clr", 128'(a_words), 128'(0));
    a_valid = 1'b0;

    // T5b: reset at clear address 50
    for (int i = 0; i < 50; i++) step();
    chk("t5_clraddr50", 128'(a_clraddr), 128'(50));
    a_rst = 1'b1;
    step();
    a_rst = 1'b0;
    chk("t5_rst_clrwe", 128'(a_clrwe), 128'(0));
    chk("t5_rst_clraddr", 128'(a_clraddr), 128'(0));
    chk("t5_rst_busy", 128'(a_busy), 128'(0));
    chk("t5_rst_en", 128'(a_en), 128'(0));
    step();
    chk("t5_restart_clrwe", 128'(a_clrwe), 128'(1));
    chk("t5_restart_addr0", 128'(a_clraddr), 128'(0));
    step();
    chk("t5_restart_addr1", 128'(a_clraddr), 128'(1));

    // reboot in LOAD drops a coincident word
    for (int i = 0; i < 127; i++) step();
    chk("rbl_ready", 128'(a_ready), 128'(1));
    a_valid  = 1'b1;
    a_data   = 64'h77;
    a_reboot = 1'b1;
    #1;
    chk("rbl_ready_forced", 128'(a_ready), 128'(0));
    chk("rbl_imwe", 128'(a_imwe), 128'(0));
    step();
    a_valid  = 1'b0;
    a_reboot = 1'b0;
    chk("rbl_clrwe", 128'(a_clrwe), 128'(1));
    chk("rbl_words", 128'(a_words), 128'(0));

    // T3: instance B overflow, 8 words without last
    b_rst = 1'b0;
    step();
    chk("t3_clrwe", 128'(b_clrwe), 128'(2'b11));
    chk("t3_clraddr0", 128'(b_clraddr), 128'(0));
    step(); step(); step();
    chk("t3_clraddr3", 128'(b_clraddr), 128'(3));
    step();
    chk("t3_ready", 128'(b_ready), 128'(1));
    for (int k = 0; k < 8; k++) begin
      b_valid = 1'b1;
      b_data  = 64'(k + 1);
      b_last  = 1'b0;
      #1;
      chk("t3_imwe", 128'(b_imwe), 128'(1));
      chk("t3_imaddr", 128'(b_imaddr), 128'(k));
      step();
    end
    #1;
    chk("t3_err", 128'(b_err), 128'(1));
    chk("t3_ready_low", 128'(b_ready), 128'(0));
    chk("t3_imwe_low", 128'(b_imwe), 128'(0));
    chk("t3_en", 128'(b_en), 128'(0));
    chk("t3_busy", 128'(b_busy), 128'(0));
    chk("t3_words", 128'(b_words), 128'(8));
    b_valid = 1'b0;
    step(); step(); step(); step();
    chk("t3_err_sticky", 128'(b_err), 128'(1));
    chk("t3_en_stays", 128'(b_en), 128'(0));

    // T4: last on the 8th word is legal
    b_reboot_to_load();
    acc = '0;
    for (int k = 0; k < 8; k++) acc = acc ^ 64'(k + 1);
`ifdef BOOT_CHECKSUM_EN
    b_cks = acc;
`endif
    for (int k = 0; k < 8; k++) begin
      b_valid = 1'b1;
      b_data  = 64'(k + 1);
      b_last  = (k == 7);
      #1;
      chk("t4_imaddr", 128'(b_imaddr), 128'(k));
      step();
    end
    b_valid = 1'b0;
    b_last  = 1'b0;
    chk("t4_err", 128'(b_err), 128'(0));
    for (int j = 0; j < 3; j++) begin
      chk("t4_hold_xrst", 128'(b_xrst), 128'(1));
      chk("t4_hold_en", 128'(b_en), 128'(0));
      step();
    end
    chk("t4_run_en", 128'(b_en), 128'(1));
    chk("t4_run_xrst", 128'(b_xrst), 128'(0));
    chk("t4_run_err", 128'(b_err), 128'(0));
    chk("t4_words", 128'(b_words), 128'(8));

`ifdef BOOT_CHECKSUM_EN
    // T6: checksum 7 accepted, checksum 6 rejected
    for (int pass = 0; pass < 2; pass++) begin
      b_reboot_to_load();
      b_cks = (pass == 0) ? 64'd7 : 64'd6;
      for (int k = 0; k < 3; k++) begin
        b_valid = 1'b1;
        b_data  = 64'(1 << k);
        b_last  = (k == 2);
        #1;
        step();
      end
      b_valid = 1'b0;
      b_last  = 1'b0;
      if (pass == 0) begin
        chk("t6_good_err", 128'(b_err), 128'(0));
        chk("t6_good_xrst", 128'(b_xrst), 128'(1));
        step(); step(); step();
        chk("t6_good_en", 128'(b_en), 128'(1));
      end else begin
        chk("t6_bad_err", 128'(b_err), 128'(1));
        chk("t6_bad_xrst", 128'(b_xrst), 128'(0));
        step(); step(); step();
        chk("t6_bad_en", 128'(b_en), 128'(0));
      end
    end
`endif

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
